// File: rtl/debounce_inputs.sv
// ============================================================================
//  Module   : debounce_inputs
//  Brief    : Two-flop synchroniser and per-channel stability debouncer for
//             buttons and switches, with one-cycle rise/fall button pulses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_inputs #(
    parameter int NB_BTN    = 4,
    parameter int NB_SW     = 4,
    parameter int NB_DEB    = 20,
    parameter int DEB_LIMIT = 1000000
) (
    input  logic              clock,
    input  logic              ck_rst,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [NB_BTN-1:0] o_btn,
    output logic [NB_BTN-1:0] o_btn_rise,
    output logic [NB_BTN-1:0] o_btn_fall,
    output logic [NB_SW-1:0]  o_sw
);

    localparam int                c_NB_CH = NB_BTN + NB_SW;
    localparam logic [NB_DEB-1:0] c_LAST  = NB_DEB'(DEB_LIMIT - 1);
    localparam logic [NB_DEB-1:0] c_ONE   = NB_DEB'(1);
    localparam logic              c_IMM   = (DEB_LIMIT == 1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [c_NB_CH-1:0] w_pin;
    logic [c_NB_CH-1:0] w_level;
    logic [NB_BTN-1:0]  w_rise;
    logic [NB_BTN-1:0]  w_fall;

    // Buttons occupy the low channel indices, switches the high ones.
    assign w_pin = {i_sw, i_btn};

    for (genvar g = 0; g < c_NB_CH; g++) begin : g_chan
        logic              r_s1;
        logic              r_s2;
        logic              r_level;
        logic [NB_DEB-1:0] r_cnt;
        state_t            r_state;
        logic              w_diff;
        logic              w_accept;

        assign w_diff   = (r_s2 != r_level);
        assign w_accept = w_diff &&
                          (((r_state == ST_PENDING) && (r_cnt == c_LAST)) ||
                           ((r_state == ST_STABLE) && c_IMM));

        always_ff @(posedge clock) begin
            if (ck_rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
                r_state <= ST_STABLE;
            end else begin
                r_s1 <= w_pin[g];
                r_s2 <= r_s1;
                if (w_accept) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                    r_state <= ST_STABLE;
                end else begin
                    case (r_state)
                        ST_STABLE: begin
                            if (w_diff) begin
                                r_cnt   <= c_ONE;
                                r_state <= ST_PENDING;
                            end
                        end
                        ST_PENDING: begin
                            // Any return to the held level restarts qualification.
                            if (!w_diff) begin
                                r_cnt   <= '0;
                                r_state <= ST_STABLE;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                        default: begin
                            r_cnt   <= '0;
                            r_state <= ST_STABLE;
                        end
                    endcase
                end
            end
        end

        assign w_level[g] = r_level;

        if (g < NB_BTN) begin : g_pulse
            logic r_rise;
            logic r_fall;

            always_ff @(posedge clock) begin
                if (ck_rst) begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= w_accept &  r_s2;
                    r_fall <= w_accept & ~r_s2;
                end
            end

            assign w_rise[g] = r_rise;
            assign w_fall[g] = r_fall;
        end
    end

    assign o_btn      = w_level[NB_BTN-1:0];
    assign o_sw       = w_level[c_NB_CH-1:NB_BTN];
    assign o_btn_rise = w_rise;
    assign o_btn_fall = w_fall;

endmodule

`default_nettype wire
